// File: rtl/booth_r4_mul_if.sv
// Start/done handshake bundle for booth_r4_mul: operands, mode, status and product.
interface booth_r4_mul_if #(
   parameter int WIDTH = 8
);
   logic               start;
   logic               sgn;
   logic [WIDTH-1:0]   A;
   logic [WIDTH-1:0]   B;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] outR;

   modport master (
      output start, sgn, A, B,
      input  busy, done, outR
   );

   modport slave (
      input  start, sgn, A, B,
      output busy, done, outR
   );
endinterface

// File: rtl/booth_r4_mul.sv
// Multi-cycle radix-4 Booth multiplier with runtime signed/unsigned mode.
// Two multiplier bits retire per cycle; the product is held until the next done.
module booth_r4_mul #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   booth_r4_mul_if.slave bus
);
   localparam int STEPS = WIDTH / 2 + 1;
   localparam int XW    = WIDTH + 2;
   localparam int CW    = $clog2(STEPS + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [XW-1:0]      r_m;
   logic [2*XW-1:0]    r_prod;
   logic               r_bm1;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [2*WIDTH-1:0] r_outR;

   logic               w_last;
   logic               w_busy_next;
   logic               w_done_next;
   logic [XW-1:0]      w_a_ext;
   logic [XW-1:0]      w_b_ext;
   logic [2:0]         w_triplet;
   logic [XW:0]        w_m1;
   logic [XW:0]        w_m2;
   logic [XW:0]        w_hi;
   logic [XW:0]        w_addend;
   logic               w_neg;
   logic [XW:0]        w_sum;
   logic [2*XW-1:0]    w_prod_step;

   // Two extra bits let one datapath cover both signed and unsigned operands.
   assign w_a_ext = {{2{bus.sgn & bus.A[WIDTH-1]}}, bus.A};
   assign w_b_ext = {{2{bus.sgn & bus.B[WIDTH-1]}}, bus.B};
   assign w_last  = (r_cnt == CW'(STEPS));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_next = CALC;
         CALC:    if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_busy_next = 1'b0;
      w_done_next = 1'b0;
      case (r_state)
         IDLE: w_busy_next = bus.start;
         CALC: begin
            w_busy_next = 1'b1;
            w_done_next = w_last;
         end
         default: begin
            w_busy_next = 1'b0;
            w_done_next = 1'b0;
         end
      endcase
   end

   // Booth recoding of the low multiplier pair plus the bit shifted out last step.
   assign w_triplet = {r_prod[1:0], r_bm1};
   assign w_m1      = {r_m[XW-1], r_m};
   assign w_m2      = {r_m, 1'b0};
   assign w_hi      = {r_prod[2*XW-1], r_prod[2*XW-1:XW]};

   always_comb begin
      w_addend = '0;
      w_neg    = 1'b0;
      case (w_triplet)
         3'b001, 3'b010: w_addend = w_m1;
         3'b011:         w_addend = w_m2;
         3'b100: begin
            w_addend = w_m2;
            w_neg    = 1'b1;
         end
         3'b101, 3'b110: begin
            w_addend = w_m1;
            w_neg    = 1'b1;
         end
         default: w_addend = '0;
      endcase
   end

   assign w_sum       = w_neg ? (w_hi - w_addend) : (w_hi + w_addend);
   assign w_prod_step = {w_sum[XW], w_sum, r_prod[XW-1:2]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m    <= '0;
         r_prod <= '0;
         r_bm1  <= 1'b0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_outR <= '0;
      end else begin
         r_busy <= w_busy_next;
         r_done <= w_done_next;
         if (r_state == IDLE && bus.start) begin
            r_m    <= w_a_ext;
            r_prod <= {{XW{1'b0}}, w_b_ext};
            r_bm1  <= 1'b0;
            r_cnt  <= '0;
         end else if (r_state == CALC) begin
            if (w_last) begin
               r_outR <= r_prod[2*WIDTH-1:0];
            end else begin
               r_prod <= w_prod_step;
               r_bm1  <= r_prod[1];
               r_cnt  <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.outR = r_outR;
endmodule
